// File: rtl/uart_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl_if
//
// Bundles the serial line, the baud-generator handshake and the parallel
// byte output of the UART receive controller.
//
// Signals:
//   rx        raw serial line, asynchronous to clk, idle high
//   bps_sig   one-cycle mid-bit pulse from the baud generator
//   cnt_start enable to the baud generator, high for the whole frame
//   rx_data   last correctly received byte (DATA_W bits)
//   rx_done   one-cycle pulse, rx_data has just been updated
//   frame_err one-cycle pulse, stop bit sampled low and byte discarded
//   rx_busy   high whenever the receiver is not idle
//
// Modports:
//   master  the receive controller itself
//   slave   the surroundings (RX pin, baud generator, byte consumer)
// ---------------------------------------------------------------------------
interface uart_rx_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              rx;
    logic              bps_sig;
    logic              cnt_start;
    logic [DATA_W-1:0] rx_data;
    logic              rx_done;
    logic              frame_err;
    logic              rx_busy;

    modport master (
        input  rx,
        input  bps_sig,
        output cnt_start,
        output rx_data,
        output rx_done,
        output frame_err,
        output rx_busy
    );

    modport slave (
        output rx,
        output bps_sig,
        input  cnt_start,
        input  rx_data,
        input  rx_done,
        input  frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//
// UART 8N1 receive controller. The serial line is synchronised, a falling
// edge while idle starts a frame and enables the external baud generator
// (cnt_start). Every mid-bit bps_sig pulse samples the line: first the start
// bit (to reject glitches), then DATA_W data bits LSB first, then the stop
// bit. A good stop bit publishes the byte on rx_data with a one-cycle
// rx_done; a low stop bit raises a one-cycle frame_err and keeps the old
// byte. The frame is left at mid-stop-bit so the next start edge is never
// missed on back-to-back traffic.
//
// Ports:
//   clk     system clock (50 MHz, the baud generator divider assumes it)
//   rst_n   asynchronous active-low reset
//   rx_bus  uart_rx_ctrl_if master modport:
//             rx, bps_sig                      inputs
//             cnt_start, rx_data, rx_done,
//             frame_err, rx_busy               outputs
//
// Parameter:
//   DATA_W  data bits per frame, supported range 5..8; must match the
//           DATA_W of the connected interface instance.
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_ctrl_if.master rx_bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              cnt_start_q, cnt_start_d;
    logic              rx_done_q, rx_done_d;
    logic              frame_err_q, frame_err_d;

    logic              rx_s1_q, rx_s1_d;
    logic              rx_s2_q, rx_s2_d;
    logic              rx_s3_q, rx_s3_d;
    logic              fall_edge;

    // Two-flop synchroniser followed by a history flop. Everything resets to
    // the idle-high level so reset itself never looks like a start edge.
    always_comb begin
        rx_s1_d = rx_bus.rx;
        rx_s2_d = rx_s1_q;
        rx_s3_d = rx_s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx_s1_d;
            rx_s2_q <= rx_s2_d;
            rx_s3_q <= rx_s3_d;
        end
    end

    // Only a real high-to-low transition starts a frame; a line held low
    // (break, or low after a framing error) produces no edge.
    assign fall_edge = rx_s3_q & ~rx_s2_q;

    // Next-state and datapath logic. All sampling uses the synchronised
    // line and happens only on bps_sig; the flags default low so they can
    // only ever be one-cycle pulses.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        rx_data_d   = rx_data_q;
        cnt_start_d = cnt_start_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_start_d = 1'b0;
                if (fall_edge) begin
                    state_d     = START;
                    cnt_start_d = 1'b1;
                end
            end

            START: begin
                if (rx_bus.bps_sig) begin
                    if (!rx_s2_q) begin
                        state_d   = DATA;
                        bit_cnt_d = 4'd0;
                    end else begin
                        state_d     = IDLE;
                        cnt_start_d = 1'b0;
                    end
                end
            end

            DATA: begin
                if (rx_bus.bps_sig) begin
                    sh_d      = {rx_s2_q, sh_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                if (rx_bus.bps_sig) begin
                    if (rx_s2_q) begin
                        rx_data_d = sh_q;
                        rx_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d     = IDLE;
                    cnt_start_d = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                cnt_start_d = 1'b0;
            end
        endcase
    end

    // Frame state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            sh_q        <= '0;
            rx_data_q   <= '0;
            cnt_start_q <= 1'b0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            rx_data_q   <= rx_data_d;
            cnt_start_q <= cnt_start_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_bus.cnt_start = cnt_start_q;
    assign rx_bus.rx_data   = rx_data_q;
    assign rx_bus.rx_done   = rx_done_q;
    assign rx_bus.frame_err = frame_err_q;
    assign rx_bus.rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Bench for uart_rx_ctrl. A behavioural baud generator (shortened bit time
// to keep runs short) answers cnt_start with mid-bit bps_sig pulses. Frames
// are driven bit by bit on rx; a negedge monitor records every rx_done /
// frame_err event, and each scenario task compares those records against
// the bytes and error counts it expects from the frames it sent.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int DW  = 8;
    localparam int BIT = 64;
    localparam int MID = BIT / 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          clean;
    } evt_t;

    logic clk = 1'b0;
    logic rst_n;
    logic bps_force;
    int   baud_cnt;

    int   vectors;
    int   miscompares;

    logic [DW-1:0] model_data;

    evt_t done_q[$];
    int   err_total   = 0;
    int   err_dirty   = 0;
    int   busy_cycles = 0;
    logic prev_done   = 1'b0;
    logic prev_err    = 1'b0;

    uart_rx_ctrl_if #(.DATA_W(DW)) rx_if ();

    uart_rx_ctrl #(.DATA_W(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_bus (rx_if)
    );

    always #10 clk = ~clk;

    // Baud generator: counts from the first cycle cnt_start is high and
    // pulses at mid-bit, then once per bit period. bps_force lets the bench
    // inject stray pulses while the receiver is idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   baud_cnt <= 0;
        else if (!rx_if.cnt_start)    baud_cnt <= 0;
        else if (baud_cnt == BIT - 1) baud_cnt <= 0;
        else                          baud_cnt <= baud_cnt + 1;
    end

    assign rx_if.bps_sig = (rx_if.cnt_start && (baud_cnt == MID)) || bps_force;

    // Event recorder: each rx_done is logged with its byte and whether the
    // surrounding outputs looked right (cnt_start already low, idle, no
    // frame_err, not a two-cycle pulse).
    always @(negedge clk) begin
        if (rx_if.rx_done === 1'b1)
            done_q.push_back({rx_if.rx_data,
                              (rx_if.cnt_start === 1'b0) && (rx_if.frame_err === 1'b0) &&
                              (rx_if.rx_busy === 1'b0) && !prev_done});
        if (rx_if.frame_err === 1'b1) begin
            err_total = err_total + 1;
            if (!((rx_if.rx_done === 1'b0) && (rx_if.cnt_start === 1'b0) && !prev_err))
                err_dirty = err_dirty + 1;
        end
        if (rx_if.rx_busy === 1'b1) busy_cycles = busy_cycles + 1;
        prev_done = (rx_if.rx_done === 1'b1);
        prev_err  = (rx_if.frame_err === 1'b1);
    end

    initial begin
        #4_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    // Drives one frame; called and returns on a negedge.
    task automatic send_frame(input logic [DW-1:0] data, input logic stop_bit);
        rx_if.rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            rx_if.rx = data[i];
            repeat (BIT) @(negedge clk);
        end
        rx_if.rx = stop_bit;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic idle_line(input int n);
        rx_if.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int b;
        rst_n      = 1'b0;
        rx_if.rx   = 1'b1;
        bps_force  = 1'b0;
        model_data = '0;
        repeat (3) @(negedge clk);
        vectors++; if (rx_if.cnt_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cnt_start: got %b expected 0", rx_if.cnt_start); end
        vectors++; if (rx_if.rx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rx_busy: got %b expected 0", rx_if.rx_busy); end
        vectors++; if (rx_if.rx_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rx_done: got %b expected 0", rx_if.rx_done); end
        vectors++; if (rx_if.frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_err: got %b expected 0", rx_if.frame_err); end
        vectors++; if (rx_if.rx_data !== '0) begin miscompares++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_if.rx_data); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        b = busy_cycles;
        for (int i = 0; i < 5; i++) begin
            bps_force = 1'b1;
            @(negedge clk);
            bps_force = 1'b0;
            repeat (3) @(negedge clk);
        end
        vectors++; if (busy_cycles - b !== 0) begin miscompares++; $display("[TB] FAIL idle_bps_ignored: busy cycles %0d expected 0", busy_cycles - b); end
        vectors++; if (done_q.size() !== 0) begin miscompares++; $display("[TB] FAIL idle_no_done: got %0d events expected 0", done_q.size()); end
    endtask

    task automatic test_single_frame();
        int   b, e;
        evt_t ev;
        b = done_q.size();
        e = err_total;
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (2) @(negedge clk);
                vectors++; if (rx_if.cnt_start !== 1'b0) begin miscompares++; $display("[TB] FAIL cnt_start_early: got %b expected 0", rx_if.cnt_start); end
                @(negedge clk);
                vectors++; if (rx_if.cnt_start !== 1'b1) begin miscompares++; $display("[TB] FAIL cnt_start_rise: got %b expected 1", rx_if.cnt_start); end
            end
        join
        model_data = 8'h55;
        ev = (done_q.size() > b) ? done_q[b] : 'x;
        vectors++; if (done_q.size() - b !== 1) begin miscompares++; $display("[TB] FAIL single_done_count: got %0d expected 1", done_q.size() - b); end
        vectors++; if (ev.data !== 8'h55) begin miscompares++; $display("[TB] FAIL single_data: got %h expected 55", ev.data); end
        vectors++; if (ev.clean !== 1'b1) begin miscompares++; $display("[TB] FAIL single_done_pulse: got clean=%b expected 1", ev.clean); end
        vectors++; if (err_total - e !== 0) begin miscompares++; $display("[TB] FAIL single_no_err: got %0d expected 0", err_total - e); end
        vectors++; if (rx_if.rx_data !== model_data) begin miscompares++; $display("[TB] FAIL single_rx_data: got %h expected %h", rx_if.rx_data, model_data); end
    endtask

    task automatic test_reset_mid_frame();
        int   b;
        evt_t ev;
        b = done_q.size();
        fork
            send_frame(8'h3C, 1'b1);
            begin
                repeat (5 * BIT + BIT / 2) @(negedge clk);
                rst_n = 1'b0;
                #1;
                vectors++; if (rx_if.cnt_start !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_cnt_start: got %b expected 0", rx_if.cnt_start); end
                vectors++; if (rx_if.rx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_rx_busy: got %b expected 0", rx_if.rx_busy); end
                vectors++; if (rx_if.rx_done !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_rx_done: got %b expected 0", rx_if.rx_done); end
                vectors++; if (rx_if.rx_data !== '0) begin miscompares++; $display("[TB] FAIL midreset_rx_data: got %h expected 00", rx_if.rx_data); end
            end
        join
        model_data = '0;
        rst_n = 1'b1;
        idle_line(BIT);
        vectors++; if (done_q.size() - b !== 0) begin miscompares++; $display("[TB] FAIL midreset_no_done: got %0d expected 0", done_q.size() - b); end
        send_frame(8'hA5, 1'b1);
        model_data = 8'hA5;
        ev = (done_q.size() > b) ? done_q[b] : 'x;
        vectors++; if (done_q.size() - b !== 1) begin miscompares++; $display("[TB] FAIL after_reset_done_count: got %0d expected 1", done_q.size() - b); end
        vectors++; if (ev.data !== 8'hA5) begin miscompares++; $display("[TB] FAIL after_reset_data: got %h expected a5", ev.data); end
        vectors++; if (rx_if.rx_data !== model_data) begin miscompares++; $display("[TB] FAIL after_reset_rx_data: got %h expected %h", rx_if.rx_data, model_data); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] bytes [3];
        int            b;
        evt_t          ev;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h81;
        b = done_q.size();
        for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1);
        model_data = bytes[2];
        vectors++; if (done_q.size() - b !== 3) begin miscompares++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", done_q.size() - b); end
        for (int i = 0; i < 3; i++) begin
            ev = (done_q.size() > b + i) ? done_q[b + i] : 'x;
            vectors++; if (ev.data !== bytes[i] || ev.clean !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_frame%0d: got %h clean=%b expected %h clean=1", i, ev.data, ev.clean, bytes[i]); end
        end
    endtask

    task automatic test_false_start();
        int   b, e;
        evt_t ev;
        b = done_q.size();
        e = err_total;
        rx_if.rx = 1'b0;
        repeat (BIT / 4) @(negedge clk);
        rx_if.rx = 1'b1;
        vectors++; if (rx_if.rx_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL false_start_busy: got %b expected 1", rx_if.rx_busy); end
        repeat (BIT) @(negedge clk);
        vectors++; if (rx_if.rx_busy !== 1'b0 || rx_if.cnt_start !== 1'b0) begin miscompares++; $display("[TB] FAIL false_start_idle: got busy=%b cnt_start=%b expected 0 0", rx_if.rx_busy, rx_if.cnt_start); end
        vectors++; if (done_q.size() - b !== 0 || err_total - e !== 0) begin miscompares++; $display("[TB] FAIL false_start_flags: got done=%0d err=%0d expected 0 0", done_q.size() - b, err_total - e); end
        send_frame(8'h12, 1'b1);
        model_data = 8'h12;
        ev = (done_q.size() > b) ? done_q[b] : 'x;
        vectors++; if (done_q.size() - b !== 1 || ev.data !== 8'h12) begin miscompares++; $display("[TB] FAIL false_start_next: got count=%0d data=%h expected 1 12", done_q.size() - b, ev.data); end
    endtask

    task automatic test_frame_error();
        int   b, e, d;
        evt_t ev;
        b = done_q.size();
        e = err_total;
        d = err_dirty;
        send_frame(8'hC3, 1'b0);
        idle_line(BIT);
        vectors++; if (err_total - e !== 1) begin miscompares++; $display("[TB] FAIL ferr_count: got %0d expected 1", err_total - e); end
        vectors++; if (err_dirty - d !== 0) begin miscompares++; $display("[TB] FAIL ferr_pulse: got %0d bad pulses expected 0", err_dirty - d); end
        vectors++; if (done_q.size() - b !== 0) begin miscompares++; $display("[TB] FAIL ferr_no_done: got %0d expected 0", done_q.size() - b); end
        vectors++; if (rx_if.rx_data !== model_data) begin miscompares++; $display("[TB] FAIL ferr_rx_data_held: got %h expected %h", rx_if.rx_data, model_data); end
        send_frame(8'h7E, 1'b1);
        model_data = 8'h7E;
        ev = (done_q.size() > b) ? done_q[b] : 'x;
        vectors++; if (done_q.size() - b !== 1 || ev.data !== 8'h7E) begin miscompares++; $display("[TB] FAIL ferr_next: got count=%0d data=%h expected 1 7e", done_q.size() - b, ev.data); end
    endtask

    task automatic test_break();
        int            b, e, busy0;
        logic [DW-1:0] data;
        evt_t          ev;
        data = DW'($urandom);
        b = done_q.size();
        e = err_total;
        send_frame(data, 1'b0);
        busy0 = busy_cycles;
        repeat (20 * BIT) @(negedge clk);
        vectors++; if (busy_cycles - busy0 !== 0) begin miscompares++; $display("[TB] FAIL break_busy: got %0d busy cycles expected 0", busy_cycles - busy0); end
        vectors++; if (err_total - e !== 1 || done_q.size() - b !== 0) begin miscompares++; $display("[TB] FAIL break_flags: got err=%0d done=%0d expected 1 0", err_total - e, done_q.size() - b); end
        vectors++; if (rx_if.rx_data !== model_data) begin miscompares++; $display("[TB] FAIL break_rx_data: got %h expected %h", rx_if.rx_data, model_data); end
        idle_line(BIT);
        vectors++; if (busy_cycles - busy0 !== 0) begin miscompares++; $display("[TB] FAIL break_rise_busy: got %0d busy cycles expected 0", busy_cycles - busy0); end
        data = DW'($urandom);
        send_frame(data, 1'b1);
        model_data = data;
        ev = (done_q.size() > b) ? done_q[b] : 'x;
        vectors++; if (done_q.size() - b !== 1 || ev.data !== data) begin miscompares++; $display("[TB] FAIL break_next: got count=%0d data=%h expected 1 %h", done_q.size() - b, ev.data, data); end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] data;
        logic          good;
        int            b, e, exp_err;
        evt_t          ev;
        b = done_q.size();
        e = err_total;
        exp_err = 0;
        for (int n = 0; n < 24; n++) begin
            data = DW'($urandom);
            good = ($urandom_range(0, 7) != 0);
            send_frame(data, good);
            if (good) begin
                exp_q.push_back(data);
                model_data = data;
                idle_line($urandom_range(0, 2 * BIT));
            end else begin
                exp_err++;
                idle_line($urandom_range(BIT, 2 * BIT));
            end
        end
        vectors++; if (done_q.size() - b !== exp_q.size()) begin miscompares++; $display("[TB] FAIL rand_done_count: got %0d expected %0d", done_q.size() - b, exp_q.size()); end
        vectors++; if (err_total - e !== exp_err) begin miscompares++; $display("[TB] FAIL rand_err_count: got %0d expected %0d", err_total - e, exp_err); end
        for (int i = 0; i < exp_q.size(); i++) begin
            ev = (done_q.size() > b + i) ? done_q[b + i] : 'x;
            vectors++; if (ev.data !== exp_q[i] || ev.clean !== 1'b1) begin miscompares++; $display("[TB] FAIL rand_frame%0d: got %h clean=%b expected %h clean=1", i, ev.data, ev.clean, exp_q[i]); end
        end
        vectors++; if (rx_if.rx_data !== model_data) begin miscompares++; $display("[TB] FAIL rand_rx_data: got %h expected %h", rx_if.rx_data, model_data); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_frame();
        test_reset_mid_frame();
        test_back_to_back();
        test_false_start();
        test_frame_error();
        test_break();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
